pc_sequencer: RTL

- Owns the program counter and sequences instruction-memory fetch addresses for the fetch stage.
- Arbitrates between PC sources: sequential increment, stall hold, return, jump and interrupt entry.
- Runs the multi-cycle interrupt entry handshake with the stack/memory stage (return-PC push, then vector load).
- Sits between hazard/branch/stack logic and the instruction memory address port.

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_next_sel.sv | 26 ++
 rtl/pc_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [3:0] {
    RUN,
    INT_SAVE,
    INT_VEC,
    RV_LO,
    RV_HI,
    RV_LD,
    IV_LO,
    IV_HI,
    IV_LD
  } pc_seq_state_e;

  localparam int unsigned DEF_PC_W        = 32;
  localparam int unsigned DEF_INSTR_BYTES = 2;
  localparam int unsigned DEF_RESET_PC    = 32;
  localparam int unsigned DEF_INT_PC      = 0;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: return beats jump, which beats sequential increment.
module pc_next_sel #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned INSTR_BYTES = 2
) (
  input  logic [PC_W-1:0] pc,
  input  logic            ret_taken,
  input  logic [PC_W-1:0] ret_pc,
  input  logic            jump_taken,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] tgt,
  output logic            redirect
);

  always_comb begin
    if (ret_taken)
      tgt = ret_pc;
    else if (jump_taken)
      tgt = jump_target;
    else
      tgt = pc + PC_W'(INSTR_BYTES); // modulo 2^PC_W, no carry out
  end

  assign redirect = ret_taken | jump_taken;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch-address sequencer with interrupt entry handshake.
// Define PC_SEQ_VECTOR_FETCH_EN to load reset/interrupt PCs indirectly from a vector table.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned    PC_W        = DEF_PC_W,
  parameter int unsigned    INSTR_BYTES = DEF_INSTR_BYTES,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(DEF_RESET_PC),
  parameter logic [PC_W-1:0] INT_PC     = PC_W'(DEF_INT_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            jump_taken,
  input  logic [PC_W-1:0] jump_target,
  input  logic            ret_taken,
  input  logic [PC_W-1:0] ret_pc,
  input  logic            int_req,
  input  logic            int_push_ack,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic            int_push_valid,
  output logic [PC_W-1:0] int_push_pc,
  output logic            int_ack
`ifdef PC_SEQ_VECTOR_FETCH_EN
  ,
  output logic            vec_rd_en,
  output logic [PC_W-1:0] vec_rd_addr,
  input  logic [15:0]     vec_rd_data
`endif
);

`ifdef PC_SEQ_VECTOR_FETCH_EN
  localparam pc_seq_state_e RESET_STATE = RV_LO;
  localparam pc_seq_state_e VEC_STATE   = IV_LO;
`else
  localparam pc_seq_state_e RESET_STATE = RUN;
  localparam pc_seq_state_e VEC_STATE   = INT_VEC;
`endif

  pc_seq_state_e   state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [PC_W-1:0] push_pc_reg, push_pc_next;
  logic            push_valid_reg, push_valid_next;
  logic            flush_reg, flush_next;
  logic            int_ack_reg, int_ack_next;
  logic            pending_reg, pending_next;
  // A request seen while an entry is already in service is kept for a follow-up entry.
  logic            rearm_reg, rearm_next;
  logic [PC_W-1:0] tgt;
  logic            redirect;
`ifdef PC_SEQ_VECTOR_FETCH_EN
  logic [15:0]     vec_lo_reg, vec_lo_next;
`endif

  pc_next_sel #(
    .PC_W        (PC_W),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_next_sel (
    .pc          (pc_reg),
    .ret_taken   (ret_taken),
    .ret_pc      (ret_pc),
    .jump_taken  (jump_taken),
    .jump_target (jump_target),
    .tgt         (tgt),
    .redirect    (redirect)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= RESET_STATE;
      pc_reg         <= RESET_PC;
      push_pc_reg    <= '0;
      push_valid_reg <= 1'b0;
      flush_reg      <= 1'b0;
      int_ack_reg    <= 1'b0;
      pending_reg    <= 1'b0;
      rearm_reg      <= 1'b0;
`ifdef PC_SEQ_VECTOR_FETCH_EN
      vec_lo_reg     <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      push_pc_reg    <= push_pc_next;
      push_valid_reg <= push_valid_next;
      flush_reg      <= flush_next;
      int_ack_reg    <= int_ack_next;
      pending_reg    <= pending_next;
      rearm_reg      <= rearm_next;
`ifdef PC_SEQ_VECTOR_FETCH_EN
      vec_lo_reg     <= vec_lo_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    push_pc_next    = push_pc_reg;
    push_valid_next = push_valid_reg;
    flush_next      = 1'b0;
    int_ack_next    = 1'b0;
    pending_next    = pending_reg | int_req;
    rearm_next      = 1'b0;
`ifdef PC_SEQ_VECTOR_FETCH_EN
    vec_lo_next     = vec_lo_reg;
`endif
    case (state_reg)
      RUN: begin
        if (!stall) begin
          // The redirect target is saved as the return PC so no instruction is skipped.
          if (pending_reg || int_req) begin
            push_pc_next    = tgt;
            push_valid_next = 1'b1;
            flush_next      = 1'b1;
            state_next      = INT_SAVE;
          end else begin
            pc_next    = tgt;
            flush_next = redirect;
          end
        end
      end
      INT_SAVE: begin
        rearm_next = rearm_reg | int_req;
        if (int_push_ack) begin
          push_valid_next = 1'b0;
          state_next      = VEC_STATE;
        end
      end
      INT_VEC: begin
        pc_next      = INT_PC;
        int_ack_next = 1'b1;
        pending_next = rearm_reg | int_req;
        state_next   = RUN;
      end
`ifdef PC_SEQ_VECTOR_FETCH_EN
      RV_LO: state_next = RV_HI;
      RV_HI: begin
        vec_lo_next = vec_rd_data;
        state_next  = RV_LD;
      end
      RV_LD: begin
        pc_next    = PC_W'({vec_rd_data, vec_lo_reg});
        state_next = RUN;
      end
      IV_LO: begin
        rearm_next = rearm_reg | int_req;
        state_next = IV_HI;
      end
      IV_HI: begin
        rearm_next  = rearm_reg | int_req;
        vec_lo_next = vec_rd_data;
        state_next  = IV_LD;
      end
      IV_LD: begin
        pc_next      = PC_W'({vec_rd_data, vec_lo_reg});
        int_ack_next = 1'b1;
        pending_next = rearm_reg | int_req;
        state_next   = RUN;
      end
`endif
      default: state_next = RUN;
    endcase
  end

`ifdef PC_SEQ_VECTOR_FETCH_EN
  // Low half is read at the vector address, high half at the next 16-bit word.
  always_comb begin
    vec_rd_en   = (state_reg == RV_LO) || (state_reg == RV_HI) ||
                  (state_reg == IV_LO) || (state_reg == IV_HI);
    vec_rd_addr = ((state_reg == RV_LO) || (state_reg == RV_HI)) ? RESET_PC : INT_PC;
    if ((state_reg == RV_HI) || (state_reg == IV_HI))
      vec_rd_addr = vec_rd_addr + PC_W'(2);
  end
`endif

  assign pc             = pc_reg;
  assign pc_valid       = (state_reg == RUN);
  assign flush          = flush_reg;
  assign int_push_valid = push_valid_reg;
  assign int_push_pc    = push_pc_reg;
  assign int_ack        = int_ack_reg;

endmodule
